// File: rtl/me_result_rx.sv
// me_result_rx: deserializes me266 SAD/MV result frames into a FWFT result FIFO.
// Define ME_RX_MIN_TRACK_EN to add the running-minimum SAD/MV outputs.
module me_result_rx #(
    parameter int SAD_W      = 16,
    parameter int MV_W       = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sign_sad,
    input  logic                          sad_out,
    input  logic                          x_out,
    input  logic                          y_out,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [SAD_W-1:0]              res_sad,
    output logic [MV_W-1:0]               res_x,
    output logic [MV_W-1:0]               res_y,
    output logic                          frm_err,
    output logic                          ovf,
    output logic [$clog2(FIFO_DEPTH):0]   fill
`ifdef ME_RX_MIN_TRACK_EN
    ,
    input  logic                          min_clr,
    output logic [SAD_W-1:0]              min_sad,
    output logic [MV_W-1:0]               min_x,
    output logic [MV_W-1:0]               min_y
`endif
);

    localparam int CW = $clog2(SAD_W + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int FW = PW + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(SAD_W - 1);
    localparam logic [CW-1:0] MV_BITS  = CW'(MV_W);
    localparam logic [FW-1:0] FULL_CNT = FW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK,
        WAIT_LOW
    } state_t;

    logic sign_q, sign_d;
    logic sad_bit_q, sad_bit_d;
    logic x_bit_q, x_bit_d;
    logic y_bit_q, y_bit_d;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SAD_W-1:0]  sad_sr_q, sad_sr_d;
    logic [MV_W-1:0]   x_sr_q, x_sr_d;
    logic [MV_W-1:0]   y_sr_q, y_sr_d;
    logic              push_q, push_d;
    logic              frm_err_q, frm_err_d;

    logic [SAD_W-1:0]  mem_sad_q [FIFO_DEPTH];
    logic [SAD_W-1:0]  mem_sad_d [FIFO_DEPTH];
    logic [MV_W-1:0]   mem_x_q [FIFO_DEPTH];
    logic [MV_W-1:0]   mem_x_d [FIFO_DEPTH];
    logic [MV_W-1:0]   mem_y_q [FIFO_DEPTH];
    logic [MV_W-1:0]   mem_y_d [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic              ovf_q, ovf_d;

    logic pop, full, wr_en;

`ifdef ME_RX_MIN_TRACK_EN
    logic [SAD_W-1:0]  min_sad_q, min_sad_d;
    logic [MV_W-1:0]   min_x_q, min_x_d;
    logic [MV_W-1:0]   min_y_q, min_y_d;
`endif

    always_comb begin
        sign_d    = sign_sad;
        sad_bit_d = sad_out;
        x_bit_d   = x_out;
        y_bit_d   = y_out;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sad_sr_d  = sad_sr_q;
        x_sr_d    = x_sr_q;
        y_sr_d    = y_sr_q;
        push_d    = 1'b0;
        frm_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sign_q) begin
                    sad_sr_d = {sad_sr_q[SAD_W-2:0], sad_bit_q};
                    x_sr_d   = {x_sr_q[MV_W-2:0], x_bit_q};
                    y_sr_d   = {y_sr_q[MV_W-2:0], y_bit_q};
                    cnt_d    = CW'(1);
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (!sign_q) begin
                    frm_err_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    sad_sr_d = {sad_sr_q[SAD_W-2:0], sad_bit_q};
                    if (cnt_q < MV_BITS) begin
                        x_sr_d = {x_sr_q[MV_W-2:0], x_bit_q};
                        y_sr_d = {y_sr_q[MV_W-2:0], y_bit_q};
                    end
                    if (cnt_q == LAST_BIT) begin
                        push_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = CHECK;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            CHECK: begin
                // Strobe still high: frame overran, result already queued.
                if (sign_q) begin
                    frm_err_d = 1'b1;
                    state_d   = WAIT_LOW;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_LOW: begin
                if (!sign_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop       = res_valid && res_ready;
        full      = (fill_q == FULL_CNT);
        wr_en     = push_q && (!full || pop);
        mem_sad_d = mem_sad_q;
        mem_x_d   = mem_x_q;
        mem_y_d   = mem_y_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        fill_d    = fill_q;
        ovf_d     = ovf_q || (push_q && full && !pop);
        if (wr_en) begin
            mem_sad_d[wr_ptr_q] = sad_sr_q;
            mem_x_d[wr_ptr_q]   = x_sr_q;
            mem_y_d[wr_ptr_q]   = y_sr_q;
            wr_ptr_d            = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        if (wr_en && !pop) fill_d = fill_q + FW'(1);
        else if (!wr_en && pop) fill_d = fill_q - FW'(1);
    end

`ifdef ME_RX_MIN_TRACK_EN
    // Dropped frames still count: compare on every completed frame.
    always_comb begin
        min_sad_d = min_sad_q;
        min_x_d   = min_x_q;
        min_y_d   = min_y_q;
        if (min_clr) begin
            min_sad_d = '1;
            min_x_d   = '0;
            min_y_d   = '0;
        end else if (push_q && (sad_sr_q < min_sad_q)) begin
            min_sad_d = sad_sr_q;
            min_x_d   = x_sr_q;
            min_y_d   = y_sr_q;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q    <= 1'b0;
            sad_bit_q <= 1'b0;
            x_bit_q   <= 1'b0;
            y_bit_q   <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            sad_sr_q  <= '0;
            x_sr_q    <= '0;
            y_sr_q    <= '0;
            push_q    <= 1'b0;
            frm_err_q <= 1'b0;
            mem_sad_q <= '{default: '0};
            mem_x_q   <= '{default: '0};
            mem_y_q   <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            ovf_q     <= 1'b0;
`ifdef ME_RX_MIN_TRACK_EN
            min_sad_q <= '1;
            min_x_q   <= '0;
            min_y_q   <= '0;
`endif
        end else begin
            sign_q    <= sign_d;
            sad_bit_q <= sad_bit_d;
            x_bit_q   <= x_bit_d;
            y_bit_q   <= y_bit_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sad_sr_q  <= sad_sr_d;
            x_sr_q    <= x_sr_d;
            y_sr_q    <= y_sr_d;
            push_q    <= push_d;
            frm_err_q <= frm_err_d;
            mem_sad_q <= mem_sad_d;
            mem_x_q   <= mem_x_d;
            mem_y_q   <= mem_y_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            ovf_q     <= ovf_d;
`ifdef ME_RX_MIN_TRACK_EN
            min_sad_q <= min_sad_d;
            min_x_q   <= min_x_d;
            min_y_q   <= min_y_d;
`endif
        end
    end

    assign res_valid = (fill_q != '0);
    assign res_sad   = res_valid ? mem_sad_q[rd_ptr_q] : '0;
    assign res_x     = res_valid ? mem_x_q[rd_ptr_q] : '0;
    assign res_y     = res_valid ? mem_y_q[rd_ptr_q] : '0;
    assign frm_err   = frm_err_q;
    assign ovf       = ovf_q;
    assign fill      = fill_q;

`ifdef ME_RX_MIN_TRACK_EN
    assign min_sad = min_sad_q;
    assign min_x   = min_x_q;
    assign min_y   = min_y_q;
`endif

endmodule
